// File: rtl/ras.sv
// Return address stack: circular stack of predicted return targets with checkpoint restore.
// Optional macro RAS_UNDERFLOW_GUARD_EN: a pop at count 0 leaves the pointer untouched.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        pop_valid,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    output logic [RAS_TARGET_WIDTH-1:0] ret_ra,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count
);

    localparam logic [RAS_INDEX_WIDTH:0] COUNT_FULL = RAS_INDEX_WIDTH'(RAS_ENTRIES - 1) + 1'b1;
    localparam logic [RAS_INDEX_WIDTH:0] COUNT_ZERO = '0;

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_q, index_d;
    logic [RAS_INDEX_WIDTH:0]    count_q, count_d;
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
    logic                        pop_eff;
    logic [RAS_INDEX_WIDTH-1:0]  index_inc;
    logic [RAS_INDEX_WIDTH-1:0]  index_dec;

    assign index_inc = index_q + 1'b1;
    assign index_dec = index_q - 1'b1;

`ifdef RAS_UNDERFLOW_GUARD_EN
    // An empty stack ignores pops; a push+pop then degenerates to a plain push.
    assign pop_eff = pop_valid && (count_q != COUNT_ZERO);
`else
    assign pop_eff = pop_valid;
`endif

    always_comb begin
        index_d = index_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = index_q;
        if (restore_valid) begin
            index_d = restore_index;
            count_d = restore_count;
        end else if (push_valid && pop_eff) begin
            wr_en  = 1'b1;
            wr_idx = index_q;
        end else if (push_valid) begin
            wr_en   = 1'b1;
            wr_idx  = index_inc;
            index_d = index_inc;
            if (count_q < COUNT_FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_eff) begin
            index_d = index_dec;
            if (count_q != COUNT_ZERO) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            index_q <= '0;
            count_q <= '0;
        end else begin
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_idx] <= link_pc;
        end
    end

    assign ret_ra    = stack_q[index_q];
    assign ras_index = index_q;
    assign ras_count = count_q;
    assign ras_empty = (count_q == COUNT_ZERO);

endmodule
